// File: rtl/mem_fill_responder_if.sv
// Fill-protocol bundle between the cache controller (master) and the memory responder (slave).
// MEM_PARITY_EN adds a registered even-parity bit alongside data.
interface mem_fill_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
);
  logic              miss;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] data;
  logic [IDX_W-1:0]  word_idx;
  logic              done;
  logic              busy;
  logic [3:0]        state;
`ifdef MEM_PARITY_EN
  logic              parity;
`endif

  modport master (
    output miss, addr,
    input  we, data, word_idx, done, busy, state
`ifdef MEM_PARITY_EN
    , input parity
`endif
  );

  modport slave (
    input  miss, addr,
    output we, data, word_idx, done, busy, state
`ifdef MEM_PARITY_EN
    , output parity
`endif
  );
endinterface

// File: rtl/mem_fill_responder.sv
// Memory side of the cache-miss line fill: LATENCY wait cycles, BURST_LEN words, then a done pulse.
// No backpressure; miss is ignored while busy except in DONE. MEM_PARITY_EN adds the parity output.
module mem_fill_responder #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 8,
  parameter int          LATENCY   = 4,
  parameter int          BURST_LEN = 4,
  parameter int unsigned SEED      = 32'hA5
) (
  input logic                 clk,
  input logic                 rst,
  mem_fill_responder_if.slave bus
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN - 1);
  localparam logic [DATA_W-1:0] SEED_D    = DATA_W'(SEED);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_WAIT  = 4'b0010,
    S_BURST = 4'b0100,
    S_DONE  = 4'b1000
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Low bits of base are clear, so base+i stays inside the line.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] b,
                                                input logic [IDX_W-1:0]  i);
    logic [ADDR_W-1:0] a;
    a = b + ADDR_W'(i);
    return DATA_W'(a) ^ SEED_D;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    data_d  = data_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.miss) begin
          base_d  = bus.addr & ~LINE_MASK;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_BURST;
          idx_d   = '0;
          data_d  = pattern(base_q, '0);
          we_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BURST: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          data_d = pattern(base_q, idx_q + IDX_W'(1));
          we_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.miss) begin
          base_d  = bus.addr & ~LINE_MASK;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      we_q    <= we_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.we       = we_q;
  assign bus.data     = data_q;
  assign bus.word_idx = idx_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.state    = state_q;

`ifdef MEM_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= ^data_d;
  end

  assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_mem_fill_responder.sv
// Scoreboard bench for mem_fill_responder at default parameters; parity checked when MEM_PARITY_EN is defined.
module tb_mem_fill_responder;
  logic clk = 1'b0;
  logic rst;

  mem_fill_responder_if #(.ADDR_W(8), .DATA_W(8), .IDX_W(2)) bus ();

  mem_fill_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [9:0] sb_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // words packs the four expected bytes, word 0 in the top byte.
  task automatic push_line(input logic [31:0] words);
    for (int i = 0; i < 4; i++)
      sb_q.push_back({2'(i), words[31-8*i -: 8]});
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.miss = 1'b0; bus.addr = 8'h00;
    tick; tick;
    chk_cnt++;
    if ({bus.state, bus.we, bus.done, bus.busy, bus.data, bus.word_idx} !== {4'b0001, 3'b000, 8'h00, 2'd0})
      $display("FAIL reset: state=%b we=%b done=%b busy=%b data=%h idx=%0d, need 0001/0/0/0/00/0",
               bus.state, bus.we, bus.done, bus.busy, bus.data, bus.word_idx);
    else pass_cnt++;
`ifdef MEM_PARITY_EN
    chk_cnt++;
    if (bus.parity !== 1'b0) $display("FAIL reset_parity: got %b need 0", bus.parity);
    else pass_cnt++;
`endif
    rst = 1'b0;
    tick;
  endtask

  task automatic test_fill(input logic [7:0] a, input logic [31:0] words, input string nm);
    logic [3:0] es;
    logic [9:0] exp;
    bus.miss = 1'b1; bus.addr = a;
    push_line(words);
    tick;
    bus.miss = 1'b0; bus.addr = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      es = (c <= 4) ? 4'b0010 : (c <= 8) ? 4'b0100 : (c == 9) ? 4'b1000 : 4'b0001;
      chk_cnt++;
      if ({bus.state, bus.we, bus.done, bus.busy} !== {es, (c >= 5 && c <= 8), (c == 9), (c <= 9)})
        $display("FAIL %s_timing cyc%0d: state=%b we=%b done=%b busy=%b, need state=%b we=%b done=%b busy=%b",
                 nm, c, bus.state, bus.we, bus.done, bus.busy, es, (c >= 5 && c <= 8), (c == 9), (c <= 9));
      else pass_cnt++;
      if (bus.we) begin
        chk_cnt++;
        if (sb_q.size() == 0) $display("FAIL %s_word cyc%0d: unexpected word %h", nm, c, bus.data);
        else begin
          exp = sb_q.pop_front();
          if ({bus.word_idx, bus.data} !== exp)
            $display("FAIL %s_word cyc%0d: idx=%0d data=%h, need idx=%0d data=%h",
                     nm, c, bus.word_idx, bus.data, exp[9:8], exp[7:0]);
          else pass_cnt++;
`ifdef MEM_PARITY_EN
          chk_cnt++;
          if (bus.parity !== ^exp[7:0])
            $display("FAIL %s_parity cyc%0d: got %b need %b", nm, c, bus.parity, ^exp[7:0]);
          else pass_cnt++;
`endif
        end
      end
      tick;
    end
    chk_cnt++;
    if (sb_q.size() != 0) $display("FAIL %s_missing: %0d words not seen, need 0", nm, sb_q.size());
    else pass_cnt++;
    sb_q.delete();
  endtask

  task automatic test_ignored_request;
    int we_n, done_n;
    logic [9:0] exp;
    we_n = 0; done_n = 0;
    bus.miss = 1'b1; bus.addr = 8'h13;
    push_line(32'hB5B4B7B6);
    for (int c = 1; c <= 26; c++) begin
      tick;
      if (bus.we) begin
        we_n++;
        chk_cnt++;
        if (sb_q.size() == 0) $display("FAIL ignored_word cyc%0d: unexpected word %h", c, bus.data);
        else begin
          exp = sb_q.pop_front();
          if ({bus.word_idx, bus.data} !== exp)
            $display("FAIL ignored_word cyc%0d: idx=%0d data=%h, need idx=%0d data=%h",
                     c, bus.word_idx, bus.data, exp[9:8], exp[7:0]);
          else pass_cnt++;
        end
      end
      if (bus.done) done_n++;
      if (c == 2) bus.addr = 8'h40;
      if (c == 9) begin
        chk_cnt++;
        if (bus.state !== 4'b1000) $display("FAIL ignored_done_state: got %b need 1000", bus.state);
        else pass_cnt++;
        push_line(32'hE5E4E7E6);
      end
      if (c == 10) begin
        chk_cnt++;
        if (bus.state !== 4'b0010) $display("FAIL ignored_rewait: got %b need 0010", bus.state);
        else pass_cnt++;
        bus.miss = 1'b0;
      end
    end
    chk_cnt++;
    if (we_n != 8 || done_n != 2 || sb_q.size() != 0 || bus.state !== 4'b0001)
      $display("FAIL ignored_count: we=%0d done=%0d left=%0d state=%b, need 8/2/0/0001",
               we_n, done_n, sb_q.size(), bus.state);
    else pass_cnt++;
    sb_q.delete();
  endtask

  task automatic test_back_to_back;
    int we_n, done_n;
    logic [9:0] exp;
    we_n = 0; done_n = 0;
    bus.miss = 1'b1; bus.addr = 8'h13;
    push_line(32'hB5B4B7B6);
    tick;
    bus.miss = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.we) begin
        we_n++;
        chk_cnt++;
        if (sb_q.size() == 0) $display("FAIL b2b_word cyc%0d: unexpected word %h", c, bus.data);
        else begin
          exp = sb_q.pop_front();
          if ({bus.word_idx, bus.data} !== exp)
            $display("FAIL b2b_word cyc%0d: idx=%0d data=%h, need idx=%0d data=%h",
                     c, bus.word_idx, bus.data, exp[9:8], exp[7:0]);
          else pass_cnt++;
        end
      end
      if (bus.done) done_n++;
      if (c == 9) begin
        chk_cnt++;
        if ({bus.state, bus.done} !== 5'b10001)
          $display("FAIL b2b_done: state=%b done=%b, need 1000/1", bus.state, bus.done);
        else pass_cnt++;
        bus.miss = 1'b1; bus.addr = 8'h20;
        push_line(32'h85848786);
      end
      if (c == 10) begin
        chk_cnt++;
        if ({bus.state, bus.busy} !== 5'b00101)
          $display("FAIL b2b_no_idle: state=%b busy=%b, need 0010/1", bus.state, bus.busy);
        else pass_cnt++;
        bus.miss = 1'b0; bus.addr = 8'h00;
      end
      if (c == 18) begin
        chk_cnt++;
        if (bus.done !== 1'b1) $display("FAIL b2b_done2: done=%b need 1", bus.done);
        else pass_cnt++;
      end
      tick;
    end
    chk_cnt++;
    if (we_n != 8 || done_n != 2 || sb_q.size() != 0 || bus.state !== 4'b0001)
      $display("FAIL b2b_count: we=%0d done=%0d left=%0d state=%b, need 8/2/0/0001",
               we_n, done_n, sb_q.size(), bus.state);
    else pass_cnt++;
    sb_q.delete();
  endtask

  task automatic test_reset_mid_burst;
    int we_n, done_n;
    logic [9:0] exp;
    we_n = 0; done_n = 0;
    bus.miss = 1'b1; bus.addr = 8'h13;
    push_line(32'hB5B4B7B6);
    tick;
    bus.miss = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (bus.we) begin
        chk_cnt++;
        if (sb_q.size() == 0) $display("FAIL rstmid_word cyc%0d: unexpected word %h", c, bus.data);
        else begin
          exp = sb_q.pop_front();
          if ({bus.word_idx, bus.data} !== exp)
            $display("FAIL rstmid_word cyc%0d: idx=%0d data=%h, need idx=%0d data=%h",
                     c, bus.word_idx, bus.data, exp[9:8], exp[7:0]);
          else pass_cnt++;
        end
      end
      if (c < 7) tick;
    end
    // Cycle 7 follows the word-1 strobe; reset lands here.
    rst = 1'b1;
    tick;
    chk_cnt++;
    if ({bus.state, bus.we, bus.busy, bus.done} !== 7'b0001000)
      $display("FAIL rstmid_after: state=%b we=%b busy=%b done=%b, need 0001/0/0/0",
               bus.state, bus.we, bus.busy, bus.done);
    else pass_cnt++;
    rst = 1'b0;
    sb_q.delete();
    for (int c = 0; c < 12; c++) begin
      tick;
      if (bus.we) we_n++;
      if (bus.done) done_n++;
    end
    chk_cnt++;
    if (we_n != 0 || done_n != 0 || bus.state !== 4'b0001)
      $display("FAIL rstmid_quiet: we=%0d done=%0d state=%b, need 0/0/0001", we_n, done_n, bus.state);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    bus.miss = 1'b0;
    bus.addr = 8'h00;
    test_reset;
    test_fill(8'h13, 32'hB5B4B7B6, "basic");
    test_ignored_request;
    test_back_to_back;
    test_reset_mid_burst;
    test_fill(8'hFF, 32'h59585B5A, "top");
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
